// File: rtl/sin_seq_pkg.sv
// Shared types and helpers for the sine sample sequencer: FSM encoding,
// default widths/timing and the 17-to-16 bit saturation function.
package sin_seq_pkg;

   localparam int DEF_PHASE_W   = 16;
   localparam int DEF_IN_W      = 17;
   localparam int DEF_OUT_W     = 16;
   localparam int DEF_EN_CYCLES = 2;
   localparam int DEF_TIMEOUT   = 40;

   localparam int OUT_MAX = 32767;
   localparam int OUT_MIN = -32768;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_PUSH  = 2'd3
   } state_t;

   localparam logic signed [DEF_IN_W-1:0] SAT_HI = DEF_IN_W'(OUT_MAX);
   localparam logic signed [DEF_IN_W-1:0] SAT_LO = DEF_IN_W'(OUT_MIN);

   // Clamp the signed CORDIC result into the signed output range.
   function automatic logic [DEF_OUT_W-1:0] sat_to_out(input logic signed [DEF_IN_W-1:0] v);
      if (v > SAT_HI)
         return DEF_OUT_W'(OUT_MAX);
      else if (v < SAT_LO)
         return DEF_OUT_W'(OUT_MIN);
      else
         return v[DEF_OUT_W-1:0];
   endfunction

endpackage

// File: rtl/sin_sample_sequencer.sv
// Drives phase requests into the CORDIC sine stage, collects each result,
// saturates it and pushes it downstream over valid/ready.
module sin_sample_sequencer
   import sin_seq_pkg::*;
#(
   parameter int PHASE_W   = DEF_PHASE_W,
   parameter int IN_W      = DEF_IN_W,
   parameter int OUT_W     = DEF_OUT_W,
   parameter int EN_CYCLES = DEF_EN_CYCLES,
   parameter int TIMEOUT   = DEF_TIMEOUT
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic [PHASE_W-1:0] i_freq_word,
   input  logic [PHASE_W-1:0] i_phase_offset,
   input  logic [15:0]        i_num_samples,
   output logic               o_calc_en,
   output logic [PHASE_W-1:0] o_calc_phase,
   input  logic               i_calc_done,
   input  logic [IN_W-1:0]    i_calc_value,
   output logic               o_m_valid,
   output logic [OUT_W-1:0]   o_m_data,
   input  logic               i_m_ready,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err_timeout,
   output logic [1:0]         o_state
);

   // Output handshake: a sample transfers on any rising clk edge where
   // o_m_valid && i_m_ready; o_m_data is held from valid rise until then.

   localparam int EN_W = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
   localparam int TO_W = $clog2(TIMEOUT + 1);

   state_t             r_state;
   logic [PHASE_W-1:0] r_freq;
   logic [PHASE_W-1:0] r_phase;
   logic [15:0]        r_num;
   logic [15:0]        r_count;
   logic [EN_W-1:0]    r_en_cnt;
   logic [TO_W-1:0]    r_to_cnt;
   logic               r_stop_pend;
   logic               r_calc_en;
   logic               r_m_valid;
   logic [OUT_W-1:0]   r_m_data;
   logic               r_done;
   logic               r_err;

   logic [15:0]        w_count_nxt;
   logic [TO_W-1:0]    w_to_nxt;
   logic               w_last;

   assign w_count_nxt = r_count + 16'd1;
   assign w_to_nxt    = r_to_cnt + TO_W'(1);
   // A stop arriving in the handshake cycle itself also ends the burst there.
   assign w_last      = r_stop_pend | i_stop |
                        ((r_num != 16'd0) && (w_count_nxt == r_num));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_freq      <= '0;
         r_phase     <= '0;
         r_num       <= '0;
         r_count     <= '0;
         r_en_cnt    <= '0;
         r_to_cnt    <= '0;
         r_stop_pend <= 1'b0;
         r_calc_en   <= 1'b0;
         r_m_valid   <= 1'b0;
         r_m_data    <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state != ST_IDLE && i_stop)
            r_stop_pend <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_freq      <= i_freq_word;
                  r_num       <= i_num_samples;
                  r_phase     <= i_phase_offset;
                  r_count     <= '0;
                  r_err       <= 1'b0;
                  r_stop_pend <= 1'b0;
                  r_en_cnt    <= '0;
                  r_calc_en   <= 1'b1;
                  r_state     <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               r_to_cnt <= '0;
               if (r_en_cnt == EN_W'(EN_CYCLES - 1)) begin
                  r_calc_en <= 1'b0;
                  r_state   <= ST_WAIT;
               end else begin
                  r_en_cnt <= r_en_cnt + EN_W'(1);
               end
            end

            ST_WAIT: begin
               r_to_cnt <= w_to_nxt;
               // Completion takes priority over a timeout landing on the same cycle.
               if (i_calc_done) begin
                  r_m_data  <= sat_to_out(i_calc_value);
                  r_m_valid <= 1'b1;
                  r_state   <= ST_PUSH;
               end else if (w_to_nxt == TO_W'(TIMEOUT)) begin
                  r_err       <= 1'b1;
                  r_stop_pend <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end

            ST_PUSH: begin
               if (i_m_ready) begin
                  r_m_valid <= 1'b0;
                  r_phase   <= r_phase + r_freq;
                  r_count   <= w_count_nxt;
                  if (w_last) begin
                     r_done      <= 1'b1;
                     r_stop_pend <= 1'b0;
                     r_state     <= ST_IDLE;
                  end else begin
                     r_en_cnt  <= '0;
                     r_calc_en <= 1'b1;
                     r_state   <= ST_ISSUE;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_calc_en     = r_calc_en;
   assign o_calc_phase  = r_phase;
   assign o_m_valid     = r_m_valid;
   assign o_m_data      = r_m_data;
   assign o_busy        = (r_state != ST_IDLE);
   assign o_done        = r_done;
   assign o_err_timeout = r_err;
   assign o_state       = r_state;

endmodule

// File: tb/tb_sin_sample_sequencer.sv
// Directed bench for sin_sample_sequencer with a behavioural sine-stage stub
// and a scoreboard of {calc_phase, m_data} pairs checked at each handshake.
module tb_sin_sample_sequencer;
  import sin_seq_pkg::*;

  localparam int EN_CYC = 2;
  localparam int TO_CYC = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [15:0] i_freq_word = '0;
  logic [15:0] i_phase_offset = '0;
  logic [15:0] i_num_samples = '0;
  logic        o_calc_en;
  logic [15:0] o_calc_phase;
  logic        i_calc_done = 1'b0;
  logic [16:0] i_calc_value = '0;
  logic        o_m_valid;
  logic [15:0] o_m_data;
  logic        i_m_ready = 1'b1;
  logic        o_busy;
  logic        o_done;
  logic        o_err_timeout;
  logic [1:0]  o_state;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  logic [31:0] exp_q[$];
  int          val_q[$];

  bit          stub_respond = 1'b1;
  int          stub_lat = 2;
  bit          stub_armed = 1'b0;
  int          stub_wait = 0;
  int          en_run = 0;
  logic [15:0] issue_phase = '0;

  sin_sample_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_stop        (i_stop),
    .i_freq_word   (i_freq_word),
    .i_phase_offset(i_phase_offset),
    .i_num_samples (i_num_samples),
    .o_calc_en     (o_calc_en),
    .o_calc_phase  (o_calc_phase),
    .i_calc_done   (i_calc_done),
    .i_calc_value  (i_calc_value),
    .o_m_valid     (o_m_valid),
    .o_m_data      (o_m_data),
    .i_m_ready     (i_m_ready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err_timeout (o_err_timeout),
    .o_state       (o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // sine-stage stub: counts calc_en width, checks phase hold, answers after stub_lat
  always @(negedge clk) begin
    i_calc_done = 1'b0;
    if (!rst_n) begin
      stub_armed = 1'b0;
      en_run = 0;
    end else if (o_calc_en) begin
      en_run++;
      stub_armed = 1'b1;
      stub_wait = 0;
      issue_phase = o_calc_phase;
    end else begin
      if (en_run != 0) begin
        check("calc_en_width", 32'(en_run), 32'(EN_CYC));
        en_run = 0;
      end
      if (stub_armed) begin
        check("calc_phase_hold", 32'(o_calc_phase), 32'(issue_phase));
        if (stub_respond) begin
          if (stub_wait >= stub_lat) begin
            i_calc_done = 1'b1;
            stub_armed = 1'b0;
            if (val_q.size() == 0) begin
              fail_now("stub_no_value_for_request");
              i_calc_value = '0;
            end else begin
              i_calc_value = 17'(val_q.pop_front());
            end
          end else begin
            stub_wait++;
          end
        end
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_done) done_cnt++;
      if (o_m_valid && i_m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_sample: got phase %h data %h, required none", o_calc_phase, o_m_data);
        end else begin
          check("sample", {o_calc_phase, o_m_data}, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic start_burst(input logic [15:0] off, input logic [15:0] fw, input logic [15:0] ns);
    @(posedge clk); #1;
    i_phase_offset = off;
    i_freq_word = fw;
    i_num_samples = ns;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("start_to_calc_en", 32'(o_calc_en), 32'd1);
    check("start_busy", 32'(o_busy), 32'd1);
  endtask

  task automatic finish_test(input string name, input int exp_done);
    int k;
    k = 0;
    while (done_cnt < exp_done && k < 600) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check({name, "_done_count"}, 32'(done_cnt), 32'(exp_done));
    check({name, "_busy_low"}, 32'(o_busy), 32'd0);
    check({name, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_val_q_empty"}, 32'(val_q.size()), 32'd0);
  endtask

  task automatic wait_state(input logic [1:0] st, input string name);
    int k;
    k = 0;
    while (o_state != st && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (o_state != st) fail_now({name, "_wait_state_timeout"});
  endtask

  initial begin
    int cnt;
    int base;
    int k;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_calc_en", 32'(o_calc_en), 32'd0);
    check("rst_calc_phase", 32'(o_calc_phase), 32'd0);
    check("rst_m_valid", 32'(o_m_valid), 32'd0);
    check("rst_m_data", 32'(o_m_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err_timeout), 32'd0);
    check("rst_state", 32'(o_state), 32'(ST_IDLE));
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: quarter-turn steps, 4 samples; a stray start mid-burst must be ignored
    val_q = '{100, 12345, -200, 32000};
    exp_q.push_back({16'h0000, 16'h0064});
    exp_q.push_back({16'h4000, 16'h3039});
    exp_q.push_back({16'h8000, 16'hFF38});
    exp_q.push_back({16'hC000, 16'h7D00});
    start_burst(16'h0000, 16'd16384, 16'd4);
    repeat (3) @(posedge clk);
    #1;
    i_phase_offset = 16'h5555;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    finish_test("t1", 1);

    // 2: saturation
    val_q = '{32768, -32768, 12345, -40000, 32767};
    exp_q.push_back({16'h1000, 16'h7FFF});
    exp_q.push_back({16'h2000, 16'h8000});
    exp_q.push_back({16'h3000, 16'h3039});
    exp_q.push_back({16'h4000, 16'h8000});
    exp_q.push_back({16'h5000, 16'h7FFF});
    start_burst(16'h1000, 16'h1000, 16'd5);
    finish_test("t2", 2);

    // 3: m_ready low for 10 cycles in PUSH
    i_m_ready = 1'b0;
    val_q = '{555, -1};
    exp_q.push_back({16'h0100, 16'h022B});
    exp_q.push_back({16'h0200, 16'hFFFF});
    start_burst(16'h0100, 16'h0100, 16'd2);
    k = 0;
    while (!o_m_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_m_valid", 32'(o_m_valid), 32'd1);
      check("stall_m_data", 32'(o_m_data), 32'h022B);
      check("stall_calc_phase", 32'(o_calc_phase), 32'h0100);
      check("stall_calc_en", 32'(o_calc_en), 32'd0);
    end
    check("stall_state", 32'(o_state), 32'(ST_PUSH));
    @(posedge clk); #1 i_m_ready = 1'b1;
    finish_test("t3", 3);

    // 4: continuous, stop during WAIT of sample 3
    stub_lat = 3;
    val_q = '{1, 2, 3};
    exp_q.push_back({16'h0000, 16'h0001});
    exp_q.push_back({16'h0800, 16'h0002});
    exp_q.push_back({16'h1000, 16'h0003});
    base = hs_cnt;
    start_burst(16'h0000, 16'h0800, 16'd0);
    k = 0;
    while (!((hs_cnt - base) == 2 && o_state == ST_WAIT) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) fail_now("t4_reach_wait3_timeout");
    i_stop = 1'b1;
    @(posedge clk); #1 i_stop = 1'b0;
    finish_test("t4", 4);
    repeat (20) @(negedge clk);
    check("t4_handshakes", 32'(hs_cnt - base), 32'd3);
    check("t4_idle", 32'(o_state), 32'(ST_IDLE));
    stub_lat = 2;

    // 5: timeout, stray calc_done in IDLE, restart clears err_timeout
    stub_respond = 1'b0;
    start_burst(16'h0400, 16'h0100, 16'd1);
    wait_state(ST_WAIT, "t5");
    cnt = 0;
    while (!o_err_timeout && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_timeout_cycles", 32'(cnt), 32'(TO_CYC));
    check("t5_err", 32'(o_err_timeout), 32'd1);
    check("t5_busy", 32'(o_busy), 32'd0);
    val_q = '{999, 77};
    stub_respond = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_done", 32'(done_cnt), 32'd4);
    check("t5_idle_ignores_done", 32'(o_m_valid), 32'd0);
    check("t5_err_sticky", 32'(o_err_timeout), 32'd1);
    exp_q.push_back({16'h1234, 16'h004D});
    start_burst(16'h1234, 16'h0000, 16'd1);
    check("t5_err_cleared", 32'(o_err_timeout), 32'd0);
    finish_test("t5", 5);

    // 6: phase wrap; stop while IDLE is ignored
    @(posedge clk); #1 i_stop = 1'b1;
    @(posedge clk); #1 i_stop = 1'b0;
    val_q = '{7, 8};
    exp_q.push_back({16'hFFF0, 16'h0007});
    exp_q.push_back({16'h0010, 16'h0008});
    start_burst(16'hFFF0, 16'h0020, 16'd2);
    finish_test("t6", 6);

    // reset mid-burst
    stub_respond = 1'b0;
    start_burst(16'h2000, 16'h0010, 16'd0);
    wait_state(ST_WAIT, "t7");
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("mid_rst_calc_en", 32'(o_calc_en), 32'd0);
    check("mid_rst_calc_phase", 32'(o_calc_phase), 32'd0);
    check("mid_rst_m_valid", 32'(o_m_valid), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_err", 32'(o_err_timeout), 32'd0);
    check("mid_rst_state", 32'(o_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stub_respond = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", 32'(o_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
